// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one data-memory request per load/store,
// stalls upstream until the response arrives, and formats the returned load data.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard_stall,
   input  logic [31:0] in_pc_reg,
   input  logic [31:0] in_imm_reg,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic [2:0]  in_funct3,
   input  logic        in_br_en_reg,
   input  logic [31:0] in_alu_out_reg,
   input  logic [31:0] in_rs2_reg,
   output logic [31:0] out_pc_reg,
   output logic [31:0] out_imm_reg,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic [2:0]  out_funct3,
   output logic        out_br_en_reg,
   output logic [31:0] out_alu_out_reg,
   output logic [31:0] out_mem_data_reg,
   output logic [31:0] dmem_address,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [3:0]  dmem_byte_enable,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic        stall
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [31:0] data_q, data_d;
   logic        mem_op;
   logic [1:0]  off;

   function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                               input logic [1:0]  o,
                                               input logic [2:0]  f3);
      logic [31:0]        d;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] s;
      d = rdata >> {o, 3'b000};
      b = signed'(d[7:0]);
      h = signed'(d[15:0]);
      case (f3)
         3'b000:  s = 32'(b);
         3'b001:  s = 32'(h);
         3'b100:  s = signed'({24'h0, d[7:0]});
         3'b101:  s = signed'({16'h0, d[15:0]});
         default: s = signed'(d);
      endcase
      return unsigned'(s);
   endfunction

   // Lanes pushed past byte 3 are dropped: misaligned stores truncate silently.
   function automatic logic [3:0] store_mask(input logic [1:0] o, input logic [2:0] f3);
      logic [3:0] m;
      case (f3)
         3'b000:  m = 4'(4'b0001 << o);
         3'b001:  m = 4'(4'b0011 << o);
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   assign mem_op = in_mem_read | in_mem_write;
   assign off    = in_alu_out_reg[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         read_q  <= read_d;
         write_q <= write_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (mem_op)        state_d = ACCESS;
         ACCESS:  if (dmem_resp)     state_d = DONE;
         DONE:    if (!hazard_stall) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Request fields load on entry to ACCESS; strobes drop with the response.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      read_d  = read_q;
      write_d = write_q;
      data_d  = data_q;
      if (state_q == IDLE && mem_op) begin
         addr_d  = {in_alu_out_reg[31:2], 2'b00};
         read_d  = in_mem_read;
         write_d = !in_mem_read;
         be_d    = in_mem_read ? 4'b0000 : store_mask(off, in_funct3);
         wdata_d = in_rs2_reg << {off, 3'b000};
      end else if (state_q == ACCESS && dmem_resp) begin
         read_d  = 1'b0;
         write_d = 1'b0;
         if (read_q) data_d = format_load(dmem_rdata, off, in_funct3);
      end
   end

   always_comb begin
      stall            = (state_q == IDLE && mem_op) || (state_q == ACCESS);
      dmem_address     = addr_q;
      dmem_read        = read_q;
      dmem_write       = write_q;
      dmem_byte_enable = be_q;
      dmem_wdata       = wdata_q;
      out_pc_reg       = in_pc_reg;
      out_imm_reg      = in_imm_reg;
      out_mem_read     = in_mem_read;
      out_mem_write    = in_mem_write;
      out_funct3       = in_funct3;
      out_br_en_reg    = in_br_en_reg;
      out_alu_out_reg  = in_alu_out_reg;
      out_mem_data_reg = data_q;
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, hazard hold, reset abort, back-to-back.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst, hazard_stall;
   logic [31:0] in_pc_reg, in_imm_reg, in_alu_out_reg, in_rs2_reg;
   logic        in_mem_read, in_mem_write, in_br_en_reg;
   logic [2:0]  in_funct3;
   logic [31:0] out_pc_reg, out_imm_reg, out_alu_out_reg, out_mem_data_reg;
   logic        out_mem_read, out_mem_write, out_br_en_reg;
   logic [2:0]  out_funct3;
   logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
   logic        dmem_read, dmem_write, dmem_resp, stall;
   logic [3:0]  dmem_byte_enable;
   int          chk = 0;
   int          pass = 0;
   logic [31:0] held;

   mem_access dut (
      .clk(clk), .rst(rst), .hazard_stall(hazard_stall),
      .in_pc_reg(in_pc_reg), .in_imm_reg(in_imm_reg),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
      .in_br_en_reg(in_br_en_reg), .in_alu_out_reg(in_alu_out_reg), .in_rs2_reg(in_rs2_reg),
      .out_pc_reg(out_pc_reg), .out_imm_reg(out_imm_reg),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_funct3(out_funct3),
      .out_br_en_reg(out_br_en_reg), .out_alu_out_reg(out_alu_out_reg),
      .out_mem_data_reg(out_mem_data_reg),
      .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2);
      in_mem_read    = mr;
      in_mem_write   = mw;
      in_funct3      = f3;
      in_alu_out_reg = addr;
      in_rs2_reg     = rs2;
   endtask

   task automatic set_nop();
      set_op(1'b0, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_0000);
   endtask

   task automatic test_reset();
      rst = 1'b1; hazard_stall = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
      in_pc_reg = 32'h0; in_imm_reg = 32'h0; in_br_en_reg = 1'b0;
      set_nop();
      step(); step();
      rst = 1'b0;
      #1;
      chk++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) $display("FAIL rst_strobes got %b%b want 00", dmem_read, dmem_write); else pass++;
      chk++; if (dmem_byte_enable !== 4'b0000) $display("FAIL rst_be got %b want 0000", dmem_byte_enable); else pass++;
      chk++; if (dmem_address !== 32'h0 || dmem_wdata !== 32'h0) $display("FAIL rst_addr_wdata got %h %h want 0 0", dmem_address, dmem_wdata); else pass++;
      chk++; if (out_mem_data_reg !== 32'h0) $display("FAIL rst_data got %h want 0", out_mem_data_reg); else pass++;
      chk++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else pass++;
   endtask

   task automatic test_lw();
      set_op(1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'h0);
      #1;
      chk++; if (stall !== 1'b1 || dmem_read !== 1'b0) $display("FAIL lw_idle got stall=%b rd=%b want 1 0", stall, dmem_read); else pass++;
      step();
      chk++; if (dmem_read !== 1'b1 || dmem_write !== 1'b0) $display("FAIL lw_acc1_strobes got %b%b want 10", dmem_read, dmem_write); else pass++;
      chk++; if (dmem_address !== 32'h1000_0004) $display("FAIL lw_addr got %h want 10000004", dmem_address); else pass++;
      chk++; if (stall !== 1'b1) $display("FAIL lw_acc1_stall got %b want 1", stall); else pass++;
      step();
      chk++; if (dmem_read !== 1'b1 || stall !== 1'b1) $display("FAIL lw_acc2 got rd=%b stall=%b want 1 1", dmem_read, stall); else pass++;
      dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_1234;
      step();
      dmem_resp = 1'b0;
      chk++; if (dmem_read !== 1'b0 || stall !== 1'b0) $display("FAIL lw_done got rd=%b stall=%b want 0 0", dmem_read, stall); else pass++;
      chk++; if (out_mem_data_reg !== 32'hCAFE_1234) $display("FAIL lw_data got %h want cafe1234", out_mem_data_reg); else pass++;
      set_nop();
      step();
   endtask

   task automatic test_byte_loads();
      set_op(1'b1, 1'b0, 3'b000, 32'h2000_0003, 32'h0);
      step();
      chk++; if (dmem_address !== 32'h2000_0000) $display("FAIL lb_addr got %h want 20000000", dmem_address); else pass++;
      dmem_resp = 1'b1; dmem_rdata = 32'h80FF_FFFF;
      step();
      dmem_resp = 1'b0;
      chk++; if (out_mem_data_reg !== 32'hFFFF_FF80) $display("FAIL lb_data got %h want ffffff80", out_mem_data_reg); else pass++;
      step();
      set_op(1'b1, 1'b0, 3'b100, 32'h2000_0003, 32'h0);
      step();
      dmem_resp = 1'b1;
      step();
      dmem_resp = 1'b0;
      chk++; if (out_mem_data_reg !== 32'h0000_0080) $display("FAIL lbu_data got %h want 00000080", out_mem_data_reg); else pass++;
      set_nop();
      step();
   endtask

   task automatic test_stores();
      set_op(1'b0, 1'b1, 3'b001, 32'h3000_0006, 32'h0000_BEEF);
      step();
      chk++; if (dmem_byte_enable !== 4'b1100) $display("FAIL sh_be got %b want 1100", dmem_byte_enable); else pass++;
      chk++; if (dmem_wdata !== 32'hBEEF_0000) $display("FAIL sh_wdata got %h want beef0000", dmem_wdata); else pass++;
      chk++; if (dmem_address !== 32'h3000_0004) $display("FAIL sh_addr got %h want 30000004", dmem_address); else pass++;
      chk++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0) $display("FAIL sh_strobes got %b%b want 01", dmem_read, dmem_write); else pass++;
      step();
      chk++; if (dmem_write !== 1'b1) $display("FAIL sh_hold got %b want 1", dmem_write); else pass++;
      dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
      step();
      dmem_resp = 1'b0;
      chk++; if (dmem_write !== 1'b0) $display("FAIL sh_drop got %b want 0", dmem_write); else pass++;
      chk++; if (out_mem_data_reg !== 32'h0000_0080) $display("FAIL sh_nodata got %h want 00000080", out_mem_data_reg); else pass++;
      step();
      set_op(1'b0, 1'b1, 3'b001, 32'h3000_0007, 32'h1234_5678);
      step();
      chk++; if (dmem_byte_enable !== 4'b1000 || dmem_wdata !== 32'h7800_0000) $display("FAIL sh_trunc got %b %h want 1000 78000000", dmem_byte_enable, dmem_wdata); else pass++;
      dmem_resp = 1'b1;
      step();
      dmem_resp = 1'b0;
      step();
      set_op(1'b0, 1'b1, 3'b010, 32'h3000_0008, 32'hA5A5_5A5A);
      step();
      chk++; if (dmem_byte_enable !== 4'b1111 || dmem_wdata !== 32'hA5A5_5A5A) $display("FAIL sw got %b %h want 1111 a5a55a5a", dmem_byte_enable, dmem_wdata); else pass++;
      dmem_resp = 1'b1;
      step();
      dmem_resp = 1'b0;
      set_nop();
      step();
   endtask

   task automatic test_hazard_hold();
      set_op(1'b1, 1'b0, 3'b001, 32'h4000_0002, 32'h0);
      step();
      dmem_resp = 1'b1; dmem_rdata = 32'h8001_1234;
      hazard_stall = 1'b1;
      step();
      dmem_resp = 1'b0;
      held = 32'hFFFF_8001;
      for (int i = 0; i < 4; i++) begin
         chk++; if (stall !== 1'b0 || dmem_read !== 1'b0 || out_mem_data_reg !== held) $display("FAIL hold_%0d got stall=%b rd=%b data=%h want 0 0 %h", i, stall, dmem_read, out_mem_data_reg, held); else pass++;
         step();
      end
      hazard_stall = 1'b0;
      set_nop();
      step();
      chk++; if (stall !== 1'b0 || dmem_read !== 1'b0) $display("FAIL hold_exit got stall=%b rd=%b want 0 0", stall, dmem_read); else pass++;
   endtask

   task automatic test_reset_mid_access();
      set_op(1'b1, 1'b0, 3'b010, 32'h5000_0008, 32'h0);
      step();
      chk++; if (dmem_read !== 1'b1) $display("FAIL rmid_req got %b want 1", dmem_read); else pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_nop();
      #1;
      chk++; if (dmem_read !== 1'b0 || stall !== 1'b0 || out_mem_data_reg !== 32'h0) $display("FAIL rmid_after got rd=%b stall=%b data=%h want 0 0 0", dmem_read, stall, out_mem_data_reg); else pass++;
      dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      step();
      dmem_resp = 1'b0;
      chk++; if (dmem_read !== 1'b0 || stall !== 1'b0 || out_mem_data_reg !== 32'h0) $display("FAIL rmid_late_resp got rd=%b stall=%b data=%h want 0 0 0", dmem_read, stall, out_mem_data_reg); else pass++;
   endtask

   task automatic test_back_to_back();
      int stall_cycles = 0;
      int read_cycles = 0;
      in_pc_reg = 32'h0000_0040; in_imm_reg = 32'h0000_0007; in_br_en_reg = 1'b1;
      set_op(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0000_0099);
      #1;
      chk++; if (stall !== 1'b0 || out_alu_out_reg !== 32'h0000_0055) $display("FAIL add_pass got stall=%b alu=%h want 0 00000055", stall, out_alu_out_reg); else pass++;
      chk++; if (out_pc_reg !== 32'h0000_0040 || out_imm_reg !== 32'h0000_0007 || out_br_en_reg !== 1'b1) $display("FAIL add_fields got %h %h %b want 00000040 00000007 1", out_pc_reg, out_imm_reg, out_br_en_reg); else pass++;
      step();
      in_pc_reg = 32'h0000_0044;
      set_op(1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'h0);
      for (int c = 0; c < 5; c++) begin
         #1;
         if (stall) stall_cycles++;
         if (dmem_read) read_cycles++;
         dmem_resp = (c == 2);
         dmem_rdata = 32'h0BAD_F00D;
         step();
         dmem_resp = 1'b0;
         if (c == 3) set_nop();
      end
      chk++; if (stall_cycles != 3 || read_cycles != 2) $display("FAIL b2b_timing got stall=%0d rd=%0d want 3 2", stall_cycles, read_cycles); else pass++;
      chk++; if (out_mem_data_reg !== 32'h0BAD_F00D) $display("FAIL b2b_data got %h want 0badf00d", out_mem_data_reg); else pass++;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_byte_loads();
      test_stores();
      test_hazard_hold();
      test_reset_mid_access();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule
